// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, line-level constants and parity types.
// Used by both the RX and TX paths of the UART system.
package uart_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StStart  = 3'd1,
        StData   = 3'd2,
        StParity = 3'd3,
        StStop   = 3'd4
    } uart_state_e;

    typedef enum logic {
        ParEven = 1'b0,
        ParOdd  = 1'b1
    } par_type_e;

    localparam logic IDLE_BIT  = 1'b1;
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Per-bit edge counter and 3-sample majority vote around the bit centre.
// sampled_bit_o is stable from edge_cnt = P/2+2 until the next bit's first sample.
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  rx_i,
    input  logic                  run_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    output logic                  sampled_bit_o,
    output logic                  bit_done_o
);

    logic [PRESCALE_W-1:0] edge_cnt_q;
    logic [PRESCALE_W-1:0] half;
    logic [2:0]            samples_q;

    assign half          = prescale_i >> 1;
    assign bit_done_o    = run_i && (edge_cnt_q == prescale_i - PRESCALE_W'(1));
    assign sampled_bit_o = majority3(samples_q[0], samples_q[1], samples_q[2]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            edge_cnt_q <= '0;
            samples_q  <= '0;
        end else begin
            // Counter parks at 0 while idle so a fresh start begins at edge_cnt = 0.
            if (!run_i || bit_done_o) begin
                edge_cnt_q <= '0;
            end else begin
                edge_cnt_q <= edge_cnt_q + PRESCALE_W'(1);
            end
            if (run_i) begin
                if (edge_cnt_q == half - PRESCALE_W'(1)) samples_q[0] <= rx_i;
                if (edge_cnt_q == half)                  samples_q[1] <= rx_i;
                if (edge_cnt_q == half + PRESCALE_W'(1)) samples_q[2] <= rx_i;
            end
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start/data/parity/stop FSM over an oversampling majority-vote sampler.
// Define UART_RX_SYNC_EN to pass RX_IN through a 2-flop synchronizer (adds 2 CLK latency).
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned PRESCALE_W = 6
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err
);

    localparam int unsigned BitCntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    logic                  rx_line;
    uart_state_e           state_q;
    logic [PRESCALE_W-1:0] prescale_q;
    logic [BitCntW-1:0]    bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] p_data_q;
    logic                  data_valid_q;
    logic                  par_err_q;
    logic                  stop_err_q;
    logic                  sampled_bit;
    logic                  bit_done;
    logic                  start_det;
    logic                  par_exp;

`ifdef UART_RX_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_q <= {2{IDLE_BIT}};
        end else begin
            sync_q <= {sync_q[0], RX_IN};
        end
    end

    assign rx_line = sync_q[1];
`else
    assign rx_line = RX_IN;
`endif

    assign start_det = (rx_line == START_BIT);
    assign par_exp   = (^shift_q) ^ (par_type_e'(PAR_TYP) == ParOdd);

    uart_rx_sampler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_sampler (
        .clk_i         (CLK),
        .rst_i         (RST),
        .rx_i          (rx_line),
        .run_i         (state_q != StIdle),
        .prescale_i    (prescale_q),
        .sampled_bit_o (sampled_bit),
        .bit_done_o    (bit_done)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= StIdle;
            prescale_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stop_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_det) begin
                        state_q    <= StStart;
                        prescale_q <= Prescale;
                        par_err_q  <= 1'b0;
                        stop_err_q <= 1'b0;
                    end
                end
                StStart: begin
                    if (bit_done) begin
                        bit_cnt_q <= '0;
                        state_q   <= (sampled_bit == IDLE_BIT) ? StIdle : StData;
                    end
                end
                StData: begin
                    if (bit_done) begin
                        shift_q <= DATA_WIDTH'({sampled_bit, shift_q} >> 1);
                        if (bit_cnt_q == BitCntW'(DATA_WIDTH - 1)) begin
                            state_q <= PAR_EN ? StParity : StStop;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BitCntW'(1);
                        end
                    end
                end
                StParity: begin
                    if (bit_done) begin
                        par_err_q <= (sampled_bit != par_exp);
                        state_q   <= StStop;
                    end
                end
                StStop: begin
                    if (bit_done) begin
                        stop_err_q <= (sampled_bit != STOP_BIT);
                        if (sampled_bit == STOP_BIT && !par_err_q) begin
                            p_data_q     <= shift_q;
                            data_valid_q <= 1'b1;
                        end
                        // Back-to-back frame: the next start bit clears the flags just set.
                        if (start_det) begin
                            state_q    <= StStart;
                            prescale_q <= Prescale;
                            par_err_q  <= 1'b0;
                            stop_err_q <= 1'b0;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_Valid = data_valid_q;
    assign Par_Err    = par_err_q;
    assign Stop_Err   = stop_err_q;

endmodule
